hazard_stall_unit: RTL and testbench

//  Decode-side pipeline control feeding the XM/MW forwarding logic: detects hazards forwarding cannot cover
//  (load-use, branch operands still in flight) and sequences the multicycle mult/div unit.

---
 rtl/hazard_stall_unit_pkg.sv | 33 +++
 rtl/hazard_stall_unit_if.sv | 48 ++++
 rtl/hazard_stall_unit_md_sequencer.sv | 82 ++++++++
 rtl/hazard_stall_unit.sv | 105 ++++++++++
 tb/tb_hazard_stall_unit.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared encodings for the decode-side hazard/stall control: mult/div sequencer
// states, stall cause codes and the source-match helper.
package hazard_stall_unit_pkg;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'd0,
        MD_START = 2'd1,
        MD_BUSY  = 2'd2,
        MD_DONE  = 2'd3
    } mdState_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_LOAD_USE = 2'd1,
        CAUSE_BRANCH   = 2'd2,
        CAUSE_MULDIV   = 2'd3
    } stallCause_t;

    localparam logic [4:0] REG_RSTATUS = 5'd30;
    localparam logic [4:0] REG_ZERO    = 5'd0;

    // r0 is hardwired, so a write to it never creates a dependency.
    function automatic logic srcMatch(
        input logic [4:0] r,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       useRs,
        input logic       useRt
    );
        return (r != REG_ZERO) && ((useRs && (rs == r)) || (useRt && (rt == r)));
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Decode/execute control bundle between the pipeline datapath and hazard_stall_unit.
interface hazard_stall_unit_if;
    import hazard_stall_unit_pkg::*;

    logic [4:0] fd_rs;
    logic [4:0] fd_rt;
    logic       fd_use_rs;
    logic       fd_use_rt;
    logic       fd_is_branch;
    logic       take_branch;
    logic [4:0] dx_rd;
    logic [4:0] xm_rd;
    logic       dx_regWrite;
    logic       dx_is_load;
    logic       xm_is_load;
    logic       dx_is_md;
    logic       md_ready;
    logic       md_exc;

    logic       pc_en;
    logic       fd_en;
    logic       dx_en;
    logic       fd_flush;
    logic       dx_bubble;
    logic       xm_bubble;
    logic       md_start;
    logic       md_busy;
    logic       md_timeout;
    logic       rstatus_wr;
    logic [1:0] stall_cause;

    modport master (
        output fd_rs, fd_rt, fd_use_rs, fd_use_rt, fd_is_branch, take_branch,
               dx_rd, xm_rd, dx_regWrite, dx_is_load, xm_is_load, dx_is_md,
               md_ready, md_exc,
        input  pc_en, fd_en, dx_en, fd_flush, dx_bubble, xm_bubble,
               md_start, md_busy, md_timeout, rstatus_wr, stall_cause
    );

    modport slave (
        input  fd_rs, fd_rt, fd_use_rs, fd_use_rt, fd_is_branch, take_branch,
               dx_rd, xm_rd, dx_regWrite, dx_is_load, xm_is_load, dx_is_md,
               md_ready, md_exc,
        output pc_en, fd_en, dx_en, fd_flush, dx_bubble, xm_bubble,
               md_start, md_busy, md_timeout, rstatus_wr, stall_cause
    );

endinterface

// File: rtl/hazard_stall_unit_md_sequencer.sv
// Mult/div sequencer: issues the start pulse, freezes the pipe while the unit
// works, and bounds the wait with a watchdog.
module md_sequencer
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned MD_SLACK   = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic dxIsMd,
    input  logic mdReady,
    input  logic mdExc,
    output logic mdStart,
    output logic mdBusy,
    output logic mdFreeze,
    output logic mdDone,
    output logic mdTimeout,
    output logic rstatusWr
);

    localparam int unsigned LIMIT = MD_LATENCY + MD_SLACK;
    localparam int unsigned CW    = $clog2(LIMIT + 1);

    mdState_t      state;
    mdState_t      stateNext;
    logic [CW-1:0] cnt;
    logic          opErr;
    logic          expire;

    assign expire = (cnt == CW'(LIMIT - 1));

    always_comb begin
        stateNext = state;
        unique case (state)
            MD_IDLE:  if (dxIsMd) stateNext = MD_START;
            MD_START: stateNext = MD_BUSY;
            MD_BUSY:  if (mdReady || expire) stateNext = MD_DONE;
            MD_DONE:  stateNext = MD_IDLE;
            default:  stateNext = MD_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= MD_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // opErr is per-operation; mdTimeout stays set until reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            opErr     <= 1'b0;
            mdTimeout <= 1'b0;
        end else begin
            if (state == MD_IDLE && dxIsMd) begin
                cnt   <= '0;
                opErr <= 1'b0;
            end else if (state == MD_BUSY) begin
                if (cnt != '1) begin
                    cnt <= cnt + CW'(1);
                end
                if (mdReady) begin
                    opErr <= mdExc;
                end else if (expire) begin
                    opErr     <= 1'b1;
                    mdTimeout <= 1'b1;
                end
            end
        end
    end

    assign mdStart   = (state == MD_IDLE) && dxIsMd;
    assign mdBusy    = (state != MD_IDLE);
    assign mdFreeze  = (state == MD_BUSY);
    assign mdDone    = (state == MD_DONE);
    assign rstatusWr = (state == MD_DONE) && opErr;

endmodule

// File: rtl/hazard_stall_unit.sv
// Decode-side pipeline control: hazard detection that forwarding cannot cover,
// stall prioritisation, and mult/div sequencing.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned MD_SLACK   = 4
) (
    input  logic                clock,
    input  logic                reset,
    hazard_stall_unit_if.slave  pipe
);

    logic        mdStart;
    logic        mdBusy;
    logic        mdFreeze;
    logic        mdDone;
    logic        mdTimeout;
    logic        rstatusWr;
    logic        loadUse;
    logic        branchOp;

    logic        pcEn;
    logic        fdEn;
    logic        dxEn;
    logic        fdFlush;
    logic        dxBubble;
    logic        xmBubble;
    stallCause_t cause;

    md_sequencer #(
        .MD_LATENCY (MD_LATENCY),
        .MD_SLACK   (MD_SLACK)
    ) u_md_sequencer (
        .clock     (clock),
        .reset     (reset),
        .dxIsMd    (pipe.dx_is_md),
        .mdReady   (pipe.md_ready),
        .mdExc     (pipe.md_exc),
        .mdStart   (mdStart),
        .mdBusy    (mdBusy),
        .mdFreeze  (mdFreeze),
        .mdDone    (mdDone),
        .mdTimeout (mdTimeout),
        .rstatusWr (rstatusWr)
    );

    assign loadUse = pipe.dx_is_load &&
        srcMatch(pipe.dx_rd, pipe.fd_rs, pipe.fd_rt, pipe.fd_use_rs, pipe.fd_use_rt);

    assign branchOp = pipe.fd_is_branch &&
        ((pipe.dx_regWrite &&
          srcMatch(pipe.dx_rd, pipe.fd_rs, pipe.fd_rt, pipe.fd_use_rs, pipe.fd_use_rt)) ||
         (pipe.xm_is_load &&
          srcMatch(pipe.xm_rd, pipe.fd_rs, pipe.fd_rt, pipe.fd_use_rs, pipe.fd_use_rt)));

    // DONE lets the result into XM with every stage advancing, so hazards are masked there.
    always_comb begin
        pcEn     = 1'b1;
        fdEn     = 1'b1;
        dxEn     = 1'b1;
        fdFlush  = 1'b0;
        dxBubble = 1'b0;
        xmBubble = 1'b0;
        cause    = CAUSE_NONE;
        if (!reset) begin
            pcEn = 1'b0;
            fdEn = 1'b0;
            dxEn = 1'b0;
        end else if (mdDone) begin
            fdFlush = pipe.take_branch;
        end else if (mdFreeze) begin
            pcEn     = 1'b0;
            fdEn     = 1'b0;
            dxEn     = 1'b0;
            xmBubble = 1'b1;
            cause    = CAUSE_MULDIV;
        end else if (loadUse) begin
            pcEn     = 1'b0;
            fdEn     = 1'b0;
            dxBubble = 1'b1;
            cause    = CAUSE_LOAD_USE;
        end else if (branchOp) begin
            pcEn     = 1'b0;
            fdEn     = 1'b0;
            dxBubble = 1'b1;
            cause    = CAUSE_BRANCH;
        end else begin
            fdFlush = pipe.take_branch;
        end
    end

    assign pipe.pc_en       = pcEn;
    assign pipe.fd_en       = fdEn;
    assign pipe.dx_en       = dxEn;
    assign pipe.fd_flush    = fdFlush;
    assign pipe.dx_bubble   = dxBubble;
    assign pipe.xm_bubble   = xmBubble;
    assign pipe.stall_cause = cause;
    assign pipe.md_start    = reset && mdStart;
    assign pipe.md_busy     = reset && mdBusy;
    assign pipe.md_timeout  = reset && mdTimeout;
    assign pipe.rstatus_wr  = reset && rstatusWr;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: load-use, branch operand, mult/div
// sequencing, watchdog and asynchronous reset behaviour.
module tb_hazard_stall_unit;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    hazard_stall_unit_if bus ();

    hazard_stall_unit #(
        .MD_LATENCY (32),
        .MD_SLACK   (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .pipe  (bus.slave)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    // {pc,fd,dx,flush,dxBubble,xmBubble,start,busy,timeout,rstatus,cause}
    function automatic logic [11:0] o(input bit pc, fd, dx, fl, dxb, xmb, st, bz, to, rw,
                                      input logic [1:0] c);
        return {pc, fd, dx, fl, dxb, xmb, st, bz, to, rw, c};
    endfunction

    task automatic chk(input string tag, input logic [11:0] exp);
        logic [11:0] obs;
        obs = {bus.pc_en, bus.fd_en, bus.dx_en, bus.fd_flush, bus.dx_bubble, bus.xm_bubble,
               bus.md_start, bus.md_busy, bus.md_timeout, bus.rstatus_wr, bus.stall_cause};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic clearInputs();
        bus.fd_rs = '0; bus.fd_rt = '0; bus.fd_use_rs = 0; bus.fd_use_rt = 0;
        bus.fd_is_branch = 0; bus.take_branch = 0; bus.dx_rd = '0; bus.xm_rd = '0;
        bus.dx_regWrite = 0; bus.dx_is_load = 0; bus.xm_is_load = 0; bus.dx_is_md = 0;
        bus.md_ready = 0; bus.md_exc = 0;
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic [11:0] idleO, busyO;
        idleO = o(1,1,1,0,0,0,0,0,0,0,2'd0);
        busyO = o(0,0,0,0,0,1,0,1,0,0,2'd3);

        // Reset asserted with stall/flush-inducing inputs: everything 0.
        clearInputs();
        bus.take_branch = 1; bus.dx_is_load = 1; bus.dx_rd = 5'd3;
        bus.fd_rs = 5'd3; bus.fd_use_rs = 1; bus.dx_is_md = 1;
        #2;
        chk("reset_outputs", o(0,0,0,0,0,0,0,0,0,0,2'd0));
        cycle();
        chk("reset_held", o(0,0,0,0,0,0,0,0,0,0,2'd0));
        clearInputs();
        reset = 1'b1;
        settle();
        chk("after_reset", idleO);

        // lw r3 in DX, add reads r3; taken branch flush is suppressed by the stall.
        cycle();
        bus.dx_is_load = 1; bus.dx_rd = 5'd3; bus.fd_rs = 5'd3; bus.fd_use_rs = 1;
        bus.take_branch = 1;
        settle();
        chk("load_use", o(0,0,1,0,1,0,0,0,0,0,2'd1));
        cycle();
        bus.dx_is_load = 0;
        settle();
        chk("load_use_release_flush", o(1,1,1,1,0,0,0,0,0,0,2'd0));
        bus.take_branch = 0;

        // lw r0 feeding r0: no dependency.
        cycle();
        bus.dx_is_load = 1; bus.dx_rd = 5'd0; bus.fd_rs = 5'd0; bus.fd_use_rs = 1;
        settle();
        chk("load_r0", idleO);
        // Matching rt number but rt not used: no stall.
        bus.dx_rd = 5'd9; bus.fd_use_rs = 0; bus.fd_rt = 5'd9; bus.fd_use_rt = 0;
        settle();
        chk("load_unused_src", idleO);
        bus.fd_use_rt = 1;
        settle();
        chk("load_use_rt", o(0,0,1,0,1,0,0,0,0,0,2'd1));
        clearInputs();

        // addi r5 in DX, bne on r5 in decode: one branch-operand stall.
        cycle();
        bus.dx_regWrite = 1; bus.dx_rd = 5'd5;
        bus.fd_is_branch = 1; bus.fd_rt = 5'd5; bus.fd_use_rt = 1; bus.take_branch = 1;
        settle();
        chk("branch_dx_alu", o(0,0,1,0,1,0,0,0,0,0,2'd2));
        cycle();
        bus.dx_regWrite = 0; bus.dx_rd = 5'd0;
        settle();
        chk("branch_resolved_flush", o(1,1,1,1,0,0,0,0,0,0,2'd0));
        clearInputs();

        // lw r5 in DX then XM feeding branch: two stall cycles (load-use wins the first).
        cycle();
        bus.dx_is_load = 1; bus.dx_regWrite = 1; bus.dx_rd = 5'd5;
        bus.fd_is_branch = 1; bus.fd_rs = 5'd5; bus.fd_use_rs = 1;
        settle();
        chk("branch_lw_dx", o(0,0,1,0,1,0,0,0,0,0,2'd1));
        cycle();
        bus.dx_is_load = 0; bus.dx_regWrite = 0; bus.dx_rd = 5'd0;
        bus.xm_is_load = 1; bus.xm_rd = 5'd5;
        settle();
        chk("branch_lw_xm", o(0,0,1,0,1,0,0,0,0,0,2'd2));
        // XM non-load writer is forwarded: no stall.
        bus.xm_is_load = 0;
        settle();
        chk("branch_xm_alu", idleO);
        clearInputs();

        // mul: start in IDLE, md_ready in START ignored, 32 BUSY cycles, DONE.
        cycle();
        bus.dx_is_md = 1;
        settle();
        chk("mul_start", o(1,1,1,0,0,0,1,0,0,0,2'd0));
        cycle();
        bus.md_ready = 1;
        settle();
        chk("mul_start_state", o(1,1,1,0,0,0,0,1,0,0,2'd0));
        bus.dx_is_load = 1; bus.dx_rd = 5'd7; bus.fd_rs = 5'd7; bus.fd_use_rs = 1;
        for (int i = 0; i < 32; i++) begin
            cycle();
            bus.dx_is_md = 0;
            bus.md_ready = (i == 31);
            bus.md_exc   = (i != 31);
            settle();
            chk($sformatf("mul_busy%0d", i), busyO);
        end
        cycle();
        bus.md_ready = 0; bus.md_exc = 0;
        settle();
        chk("mul_done", o(1,1,1,0,0,0,0,1,0,0,2'd0));
        cycle();
        chk("mul_idle_load_use", o(0,0,1,0,1,0,0,0,0,0,2'd1));
        clearInputs();

        // div with exception at md_ready after 5 BUSY cycles.
        cycle();
        bus.dx_is_md = 1;
        settle();
        chk("div_start", o(1,1,1,0,0,0,1,0,0,0,2'd0));
        cycle();
        bus.dx_is_md = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            bus.md_ready = (i == 4); bus.md_exc = (i == 4);
            settle();
            chk($sformatf("div_busy%0d", i), busyO);
        end
        cycle();
        bus.md_ready = 0; bus.md_exc = 0;
        chk("div_done_rstatus", o(1,1,1,0,0,0,0,1,0,1,2'd0));
        cycle();
        chk("div_idle", idleO);

        // md_ready on the expiry cycle: normal completion, no timeout.
        bus.dx_is_md = 1;
        cycle();
        bus.dx_is_md = 0;
        for (int i = 0; i < 36; i++) begin
            cycle();
            bus.md_ready = (i == 35);
            settle();
            if (i == 35) chk("edge_busy35", busyO);
        end
        cycle();
        bus.md_ready = 0;
        chk("edge_done", o(1,1,1,0,0,0,0,1,0,0,2'd0));

        // No md_ready: watchdog expires after 36 BUSY cycles.
        cycle();
        bus.dx_is_md = 1;
        cycle();
        bus.dx_is_md = 0;
        for (int i = 0; i < 36; i++) begin
            cycle();
            if (i == 0 || i == 35) chk($sformatf("to_busy%0d", i), busyO);
        end
        cycle();
        chk("to_done", o(1,1,1,0,0,0,0,1,1,1,2'd0));
        cycle();
        chk("to_sticky", o(1,1,1,0,0,0,0,0,1,0,2'd0));

        // Reset asserted mid-BUSY aborts the operation.
        bus.dx_is_md = 1;
        cycle();
        bus.dx_is_md = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
        end
        chk("abort_busy", o(0,0,0,0,0,1,0,1,1,0,2'd3));
        #2;
        reset = 1'b0;
        settle();
        chk("abort_reset_now", o(0,0,0,0,0,0,0,0,0,0,2'd0));
        cycle();
        reset = 1'b1;
        settle();
        chk("abort_released", idleO);
        cycle();
        chk("abort_idle_no_start", idleO);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
